// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared constants, types and helpers for the 16-point FFT output reorder stage.
//   FFT_N / FFT_LOG2N / FFT_DW : frame length, address width, component width
//   cplx_t                     : packed complex sample {re, im}
//   rd_state_t                 : read-side sequencer states
//   bitrev()                   : reverses the FFT_LOG2N low bits of an index
// -----------------------------------------------------------------------------
package fft_pkg;

   localparam int FFT_N     = 16;
   localparam int FFT_LOG2N = 4;
   localparam int FFT_DW    = 12;

   typedef struct packed {
      logic signed [FFT_DW-1:0] re;
      logic signed [FFT_DW-1:0] im;
   } cplx_t;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_BUSY = 1'b1
   } rd_state_t;

   function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] a);
      logic [FFT_LOG2N-1:0] r;
      for (int b = 0; b < FFT_LOG2N; b++) begin
         r[b] = a[FFT_LOG2N-1-b];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// -----------------------------------------------------------------------------
// fft_pingpong_ram
// Two banks of N words, W bits each. Simple dual port: one write port and one
// read port, each with its own bank-select bit. Read is synchronous with one
// cycle of latency; contents are never reset.
//   clk               : system clock
//   wr_en/wr_bank     : write strobe and bank select
//   wr_addr/wr_data   : write address within bank, write word
//   rd_en/rd_bank     : read strobe and bank select
//   rd_addr           : read address within bank
//   rd_data           : registered read word (valid the cycle after rd_en)
// -----------------------------------------------------------------------------
module fft_pingpong_ram
   import fft_pkg::*;
#(
   parameter int N     = FFT_N,
   parameter int LOG2N = FFT_LOG2N,
   parameter int W     = 2*FFT_DW
)
(
   input  logic             clk,
   input  logic             wr_en,
   input  logic             wr_bank,
   input  logic [LOG2N-1:0] wr_addr,
   input  logic [W-1:0]     wr_data,
   input  logic             rd_en,
   input  logic             rd_bank,
   input  logic [LOG2N-1:0] rd_addr,
   output logic [W-1:0]     rd_data
);

   logic [W-1:0] mem [2*N];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[{wr_bank, wr_addr}] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[{rd_bank, rd_addr}];
      end
   end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder
// Takes 16-bin frames from the SDF FFT in bit-reversed order, buffers each in
// one half of a ping-pong RAM and replays it in natural order with frame
// markers and bin index. Optional magnitude output when FFT_REORDER_MAG_EN is
// defined (alpha-max-beta-min, out_mag port).
//   clk, rst_n              : clock, async active-low reset
//   in_valid, in_sop        : input bin strobe, first-bin marker
//   in_r, in_i              : input bin, bit-reversed order
//   out_valid/sop/eop/idx   : natural-order bin strobe, bin 0 / bin N-1, index
//   out_r, out_i            : output bin (0 when out_valid is low)
//   out_mag                 : |bin| estimate (FFT_REORDER_MAG_EN only)
//   frame_err               : one-cycle pulse when an early in_sop drops a frame
//
// Read sequencer
//   state   | meaning
//   RD_IDLE | no frame being replayed
//   RD_BUSY | replaying rd_bank, address rd_cnt, one bin per cycle
// -----------------------------------------------------------------------------
module fft_bitrev_reorder
   import fft_pkg::*;
#(
   parameter int N     = FFT_N,
   parameter int LOG2N = FFT_LOG2N,
   parameter int DW    = FFT_DW
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic                 in_sop,
   input  logic signed [DW-1:0] in_r,
   input  logic signed [DW-1:0] in_i,
   output logic                 out_valid,
   output logic                 out_sop,
   output logic                 out_eop,
   output logic [LOG2N-1:0]     out_idx,
   output logic signed [DW-1:0] out_r,
   output logic signed [DW-1:0] out_i,
`ifdef FFT_REORDER_MAG_EN
   output logic [DW-1:0]        out_mag,
`endif
   output logic                 frame_err
);

   localparam logic [LOG2N-1:0] LAST = LOG2N'(N-1);

   logic [LOG2N-1:0] wr_cnt;
   logic             wr_bank;
   logic [LOG2N-1:0] wr_addr;
   logic             resync;
   logic             frame_done;
   cplx_t            wr_data;
   cplx_t            rd_data;

   rd_state_t        rd_state;
   rd_state_t        rd_state_nxt;
   logic             rd_active;
   logic [LOG2N-1:0] rd_cnt;
   logic             rd_bank;

   // An in_sop mid-frame restarts the current bank: the sample is bin 0 again.
   assign resync     = in_valid & in_sop & (wr_cnt != '0);
   assign frame_done = in_valid & ~resync & (wr_cnt == LAST);
   assign wr_addr    = resync ? '0 : bitrev(wr_cnt);
   assign wr_data.re = in_r;
   assign wr_data.im = in_i;
   assign rd_active  = (rd_state == RD_BUSY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt    <= '0;
         wr_bank   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= resync;
         if (in_valid) begin
            if (resync) begin
               wr_cnt <= LOG2N'(1);
            end else begin
               wr_cnt <= wr_cnt + 1'b1;
            end
         end
         if (frame_done) begin
            wr_bank <= ~wr_bank;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state <= RD_IDLE;
      end else begin
         rd_state <= rd_state_nxt;
      end
   end

   // A completion landing on the last read cycle chains straight into the
   // next replay, keeping back-to-back frames gap-free.
   always_comb begin
      rd_state_nxt = rd_state;
      case (rd_state)
         RD_IDLE: if (frame_done) rd_state_nxt = RD_BUSY;
         RD_BUSY: if ((rd_cnt == LAST) && !frame_done) rd_state_nxt = RD_IDLE;
         default: rd_state_nxt = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt  <= '0;
         rd_bank <= 1'b0;
      end else if (frame_done) begin
         rd_cnt  <= '0;
         rd_bank <= wr_bank;
      end else if (rd_active) begin
         rd_cnt  <= rd_cnt + 1'b1;
      end
   end

   fft_pingpong_ram #(
      .N     (N),
      .LOG2N (LOG2N),
      .W     (2*DW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (in_valid),
      .wr_bank (wr_bank),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_active),
      .rd_bank (rd_bank),
      .rd_addr (rd_cnt),
      .rd_data (rd_data)
   );

   // Markers are delayed one cycle to line up with the RAM read register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_idx   <= '0;
      end else begin
         out_valid <= rd_active;
         out_sop   <= rd_active & (rd_cnt == '0);
         out_eop   <= rd_active & (rd_cnt == LAST);
         out_idx   <= rd_active ? rd_cnt : '0;
      end
   end

   // RAM output is not reset; gating by out_valid gives clean zeros while
   // idle and the instant rst_n falls.
   assign out_r = out_valid ? rd_data.re : '0;
   assign out_i = out_valid ? rd_data.im : '0;

`ifdef FFT_REORDER_MAG_EN
   logic [DW-1:0] abs_r;
   logic [DW-1:0] abs_i;
   logic [DW-1:0] mag_max;
   logic [DW-1:0] mag_min;
   logic [DW:0]   mag_sum;

   // Most-negative value folds to the largest positive one so |x| fits DW-1 bits.
   function automatic logic [DW-1:0] abs_clip(input logic signed [DW-1:0] x);
      logic [DW-1:0] ux;
      ux = x;
      if (ux == {1'b1, {(DW-1){1'b0}}}) begin
         return {1'b0, {(DW-1){1'b1}}};
      end else if (ux[DW-1]) begin
         return ~ux + 1'b1;
      end else begin
         return ux;
      end
   endfunction

   always_comb begin
      abs_r   = abs_clip(rd_data.re);
      abs_i   = abs_clip(rd_data.im);
      mag_max = (abs_r >= abs_i) ? abs_r : abs_i;
      mag_min = (abs_r >= abs_i) ? abs_i : abs_r;
      mag_sum = {1'b0, mag_max} + {2'b00, mag_min[DW-1:1]};
      out_mag = '0;
      if (out_valid) begin
         out_mag = mag_sum[DW] ? '1 : mag_sum[DW-1:0];
      end
   end
`endif

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output stage directly downstream of the 16-point radix-2 SDF FFT pipeline, whose last stage emits bins in bit-reversed order.
- Buffers each 16-bin frame in a ping-pong memory and replays it in natural order (bin 0..15).
- Adds frame markers and a bin index for downstream consumers (spectrum readout, peak detect).

Parameters:
- N, 16, points per frame (power of 2)
- LOG2N, 4, log2(N); address width
- DW, 12, signed width of each real/imag component

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  one FFT bin present on in_r/in_i this cycle
- in_sop  in  1  qualifies the first bin of a frame (bit-reversed index 0); sampled only with in_valid
- in_r  in  DW  bin real part, signed, bit-reversed order
- in_i  in  DW  bin imag part, signed
- out_valid  out  1  natural-order bin valid
- out_sop  out  1  high with bin 0
- out_eop  out  1  high with bin N-1
- out_idx  out  LOG2N  natural bin index of current output
- out_r  out  DW  bin real part, signed
- out_i  out  DW  bin imag part, signed
- frame_err  out  1  one-cycle pulse: frame aborted by early in_sop

Behaviour:
- Reset (async, rst_n=0):
  - wr_cnt=0, wr_bank=0, rd_active=0, rd_cnt=0.
  - All outputs 0.
  - Memory contents are not reset.
- Write side:
  - On in_valid, store {in_r,in_i} at bank wr_bank, address bitrev(wr_cnt); wr_cnt increments and wraps N-1 -> 0.
  - When wr_cnt==N-1 is written: wr_bank toggles and a read of the just-filled bank is launched (rd_active=1, rd_cnt=0) in the next cycle.
  - in_valid gaps are allowed and simply pause wr_cnt.
- Resync:
  - in_valid & in_sop with wr_cnt!=0: partial frame discarded, no bank swap; sample written at address 0 of the current bank; wr_cnt=1; frame_err pulses next cycle.
  - in_sop with wr_cnt==0 is normal.
  - in_sop is ignored when in_valid=0.
- Read side:
  - While rd_active, reads address rd_cnt from the read bank, one per cycle, for N consecutive cycles, then rd_active=0.
  - Read data is registered. out_valid, out_idx=rd_cnt, out_sop (rd_cnt==0) and out_eop (rd_cnt==N-1) are delayed one cycle to align with the data.
  - Outputs are held at 0 when out_valid=0.
- Latency: out bin 0 appears 2 cycles after the cycle in which the last input bin of the frame is accepted.
- Throughput:
  - Reading takes exactly N cycles and filling the other bank needs ≥N valid inputs, so there is no overflow; no backpressure is required.
  - Last write of frame k+1 and the read of frame k never touch the same bank.
  - Back-to-back continuous frames produce a continuous output stream after initial fill.
- Simultaneous events:
  - A frame completion may coincide with the read-finish cycle; the new read starts on the following cycle with no gap beyond the fixed latency.
- Arithmetic: data passes through bit-exact; no scaling or rounding.
- Reset mid-frame: the partial frame and any in-flight read are dropped; out_valid goes low immediately (async).

Optional Feature:
- Macro: FFT_REORDER_MAG_EN.
- Defined:
  - Adds output out_mag, DW unsigned: alpha-max-beta-min approximation max(|r|,|i|) + (min(|r|,|i|)>>1), saturated to 2^DW-1.
  - |-2^(DW-1)| is taken as 2^(DW-1)-1.
  - Registered; same alignment and reset value (0) as out_r.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package fft_pkg:
  - FFT_N, FFT_LOG2N, FFT_DW constants.
  - Complex sample struct {re, im}.
  - bitrev function over LOG2N bits.
- One sub-module fft_pingpong_ram: 2×N×(2·DW) simple dual-port memory with a bank-select bit on each port, synchronous read with 1-cycle latency.

Test Plan:
- Single frame: in_valid continuous, in_r=k, in_i=-k for k=0..15 with in_sop at k=0 -> out_r sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with out_i negated; out_idx 0..15; out_sop at idx 0; out_eop at idx 15; first out_valid 2 cycles after k=15.
- Back-to-back: 4 continuous frames -> 64 consecutive out_valid cycles with no gaps after first, each frame correctly reordered.
- Gappy input: in_valid=1 every 3rd cycle -> output identical to single-frame case, bursts of 16 contiguous cycles.
- Resync: in_sop after 7 bins -> frame_err single pulse, no output for the aborted frame, next full frame reordered correctly.
- Reset mid-read: rst_n low at output bin 5 -> all outputs 0 immediately; after release, a new frame is reordered correctly starting at bank 0.
- FFT_REORDER_MAG_EN: bin (in_r=-2048, in_i=100) -> out_mag=2047+50=2097, saturated to 4095 only if the sum overflows; (300,-400) -> 550.
